// File: rtl/inst_loader.sv
// Byte-stream program loader: assembles framed 9-bit codes, writes them to instruction
// memory at consecutive addresses, verifies an XOR checksum and gates the core reset.
module inst_loader #(
  parameter int AW = 6,
  parameter int IW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          InValid,
  input  logic [7:0]    InData,
  output logic          InReady,
  output logic          WrEn,
  output logic [AW-1:0] WrAddr,
  output logic [IW-1:0] WrData,
  output logic          CoreReset,
  output logic          Busy,
  output logic          LoadDone,
  output logic          Err
);

  localparam int LW = AW + 1;
  localparam logic [8:0] MAX_N = 9'(2 ** AW);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    acc_q, acc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] left_q, left_d;
  logic [IW-1:0] data_q, data_d;
  logic          in_ready;
  logic          xfer;

  // Every output is a decode of the state register or a flop; no input-to-output paths.
  always_comb begin
    in_ready  = 1'b0;
    Busy      = 1'b1;
    LoadDone  = 1'b0;
    Err       = 1'b0;
    CoreReset = 1'b1;
    case (state_q)
      S_LEN, S_LO, S_HI, S_CHK: in_ready = 1'b1;
      S_IDLE:                   Busy = 1'b0;
      S_DONE: begin
        Busy      = 1'b0;
        LoadDone  = 1'b1;
        CoreReset = 1'b0;
      end
      S_ERR: begin
        Busy = 1'b0;
        Err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign InReady = in_ready;
  assign WrEn    = (state_q == S_WRITE);
  assign WrAddr  = addr_q;
  assign WrData  = data_q;
  assign xfer    = InValid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    left_d  = left_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_LEN;
          acc_d   = 8'd0;
          addr_d  = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          acc_d  = acc_q ^ InData;
          left_d = LW'(InData);
          if (InData == 8'd0 || {1'b0, InData} > MAX_N) state_d = S_ERR;
          else                                         state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          acc_d       = acc_q ^ InData;
          data_d[7:0] = InData;
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          acc_d = acc_q ^ InData;
          // Reserved HI bits must be zero; a malformed code is never written.
          if (InData[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            data_d[8] = InData[0];
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + AW'(1);
        left_d  = left_q - LW'(1);
        state_d = (left_q != LW'(1)) ? S_LO : S_CHK;
      end
      S_CHK: begin
        if (xfer) state_d = (InData == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      acc_q   <= 8'd0;
      addr_q  <= '0;
      left_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Byte-stream program loader for the 9-bit core: accepts a framed image over a valid/ready byte interface and assembles 9-bit machine codes. It writes them into the instruction memory's write port at consecutive addresses, then verifies an XOR checksum. It holds the core in reset (`CoreReset`) until a load completes cleanly, so the fetch path only ever reads a complete, verified image.

## Interface
- `AW`, 6: instruction address width, matching the PC width; depth = 2^AW.
- `IW`, 9: machine-code width; fixed at 9 for this frame format.
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE, ERR.
- `InValid`  in  1  byte on `InData` is valid.
- `InData`  in  8  frame byte.
- `InReady`  out  1  loader accepts the byte this cycle; transfer = `InValid & InReady`.
- `WrEn`  out  1  instruction-memory write strobe, one cycle per instruction.
- `WrAddr`  out  AW  write address.
- `WrData`  out  IW  write data (machine code).
- `CoreReset`  out  1  holds the core in reset; low only in DONE.
- `Busy`  out  1  high in every state except IDLE, DONE, ERR.
- `LoadDone`  out  1  high in DONE.
- `Err`  out  1  high in ERR.

## Operation
- Frame format: `N`, then N pairs (`LO`, `HI`), then `CHK`.
  - `N` is the instruction count, 1..2^AW.
  - `LO` = code[7:0].
  - `HI` bit0 = code[8]; `HI` bits 7:1 must be 0.
  - `CHK` = XOR of all preceding frame bytes, including `N`.
- Running checksum register `acc` (8 bits): cleared on Start, XORed with every accepted byte except `CHK`.
- Address counter `addr` (AW bits): cleared on Start, incremented after each write.
- Instruction counter `left` (AW+1 bits): loaded with N, decremented after each write.
- States and transitions:
  - IDLE → LEN on Start.
  - LEN: accept N. If N == 0 or N > 2^AW → ERR; else → LO.
  - LO: accept byte, latch it into `WrData[7:0]` → HI.
  - HI: accept byte. If bits 7:1 ≠ 0 → ERR, with no write; else latch bit0 into `WrData[8]` → WRITE.
  - WRITE: `WrEn`=1 for exactly one cycle at `addr`, then `addr`++ and `left`--. → LO if `left` after decrement ≠ 0; else → CHK.
  - CHK: accept byte. If it equals `acc` → DONE; else → ERR.
  - DONE / ERR: remain there; Start → LEN (new load; `CoreReset` re-asserts immediately).
- `InReady` = 1 only in LEN, LO, HI, CHK. It is 0 in WRITE, IDLE, DONE, ERR, so bytes offered there are not consumed.
- Start in any Busy state is ignored.
- `addr` never wraps within a load: N = 2^AW ends with its last write at address 2^AW−1.
- Any error leaves earlier writes in memory untouched. `CoreReset` stays 1.

## Timing
- Reset values: `InReady`=0, `WrEn`=0, `WrAddr`=0, `WrData`=0, `CoreReset`=1, `Busy`=0, `LoadDone`=0, `Err`=0; state IDLE, `acc`=0, `left`=0.
- Reset is asynchronous and may arrive mid-load. The loader returns to IDLE with the values above. A partially written image stays in memory, but the core stays in reset.
- All outputs are registered or decoded from state registers only; no combinational path from `InValid`/`InData` to any output.
- Start registered in cycle t → state LEN and `InReady`=1 in cycle t+1.
- A transfer in HI at edge t gives `WrEn`=1 with valid `WrAddr`/`WrData` during cycle t+1 (WRITE). Memory captures at the end of that cycle.
- Minimum 3 cycles per instruction (LO, HI, WRITE) at full `InValid`.
- Minimum frame time for N instructions is 3N+2 cycles from the first LEN cycle to entering DONE/ERR.
- `CoreReset` falls, and `LoadDone` rises, on the edge that accepts a matching `CHK`.
- Upstream may deassert `InValid` at any time. The loader waits in its current state, and `acc`/counters are unchanged.

## Test plan
- Nominal load, N=2, codes 0x1A5 and 0x003:
  - Stream 02, A5, 01, 03, 00, A5.
  - Expect WrEn pulses (addr 0, 0x1A5) and (addr 1, 0x003), then `LoadDone`=1, `CoreReset`=0, `Err`=0.
- Checksum mismatch: same frame, CHK=0x00. Both writes occur; expect `Err`=1, `CoreReset`=1, `LoadDone`=0.
- Bad HI byte: frame 01, 7F, 02. Expect `Err`=1 right after the HI transfer, no `WrEn` pulse, `InReady`=0 afterwards.
- Length bounds:
  - N=0x00 → ERR after 1 byte.
  - N=0x41 (AW=6) → ERR.
  - N=0x40 with 64 codes of value = index and a correct CHK → last write at addr 63, then DONE.
- Backpressure: nominal frame with `InValid` toggled randomly. Expect identical writes, `InReady`=0 in every WRITE cycle, and no byte lost or duplicated.
- Reset and restart:
  - Assert `Reset` after the first write of a 3-instruction frame. Expect all outputs at reset values within the same cycle.
  - Then Start plus the nominal frame → DONE, with addresses starting at 0.
  - Start while Busy → ignored.
